// File: rtl/alu_pkg.sv
// Shared definitions for alu_seq: default widths, opcode map and FSM state encoding.
// The iterative MUL/DIV datapath is enabled by defining ALU_SEQ_MULDIV_EN.
package alu_pkg;

  localparam int WORD_SIZE_DEF = 32;
  localparam int SEL_WIDTH_DEF = 6;

  localparam int OP_ADD  = 0;
  localparam int OP_SUB  = 1;
  localparam int OP_DIV  = 2;
  localparam int OP_AND  = 3;
  localparam int OP_OR   = 4;
  localparam int OP_XOR  = 5;
  localparam int OP_MUL  = 6;
  localparam int OP_SHR  = 7;
  localparam int OP_SHRA = 8;
  localparam int OP_SHL  = 9;
  localparam int OP_ROR  = 10;
  localparam int OP_ROL  = 11;
  localparam int OP_NEG  = 12;
  localparam int OP_NOT  = 13;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } alu_state_e;

  // Opcodes that run on the multi-cycle datapath.
  function automatic logic is_iter_op(input int op);
    return (op == OP_MUL) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/alu_muldiv_iter.sv
// alu_muldiv_iter: unsigned shift-add multiplier and restoring divider, one bit per cycle.
// Instantiated by alu_seq only when ALU_SEQ_MULDIV_EN is defined; hi/lo are valid while done=1.
module alu_muldiv_iter
  import alu_pkg::*;
#(
  parameter int WORD_SIZE = WORD_SIZE_DEF
) (
  input  logic                 clk,
  input  logic                 clr,
  input  logic                 start,
  input  logic                 op,
  input  logic [WORD_SIZE-1:0] A,
  input  logic [WORD_SIZE-1:0] B,
  output logic [WORD_SIZE-1:0] hi,
  output logic [WORD_SIZE-1:0] lo,
  output logic                 done
);

  localparam int CW = $clog2(WORD_SIZE);
  localparam logic [CW-1:0] LAST = CW'(WORD_SIZE - 1);

  logic                 running;
  logic                 div_q;
  logic [CW-1:0]        cnt;
  logic [WORD_SIZE-1:0] hi_r;
  logic [WORD_SIZE-1:0] lo_r;
  logic [WORD_SIZE-1:0] opnd;
  logic [WORD_SIZE:0]   mul_sum;
  logic [WORD_SIZE:0]   div_shift;
  logic                 div_ge;
  logic [WORD_SIZE-1:0] div_diff;

  // lo_r holds the multiplier (MUL) or the dividend shifting into the quotient (DIV).
  assign mul_sum   = {1'b0, hi_r} + (lo_r[0] ? {1'b0, opnd} : '0);
  assign div_shift = {hi_r, lo_r[WORD_SIZE-1]};
  assign div_ge    = div_shift >= {1'b0, opnd};
  assign div_diff  = div_shift[WORD_SIZE-1:0] - opnd;

  // hi/lo present the value after the step in progress, so the final step is visible with done.
  always_comb begin
    if (div_q) begin
      hi = div_ge ? div_diff : div_shift[WORD_SIZE-1:0];
      lo = {lo_r[WORD_SIZE-2:0], div_ge};
    end else begin
      hi = mul_sum[WORD_SIZE:1];
      lo = {mul_sum[0], lo_r[WORD_SIZE-1:1]};
    end
  end

  assign done = running && (cnt == LAST);

  always_ff @(posedge clk) begin
    if (clr) begin
      running <= 1'b0;
      div_q   <= 1'b0;
      cnt     <= '0;
      hi_r    <= '0;
      lo_r    <= '0;
      opnd    <= '0;
    end else if (start) begin
      running <= 1'b1;
      div_q   <= op;
      cnt     <= '0;
      hi_r    <= '0;
      lo_r    <= A;
      opnd    <= B;
    end else if (running) begin
      hi_r <= hi;
      lo_r <= lo;
      cnt  <= cnt + CW'(1);
      if (cnt == LAST) running <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_seq.sv
// alu_seq: sequenced ALU; single-cycle logic/arith/shift ops, optional iterative MUL/DIV.
// Define ALU_SEQ_MULDIV_EN to build MUL/DIV; otherwise opcodes 2 and 6 behave as unused codes.
module alu_seq
  import alu_pkg::*;
#(
  parameter int WORD_SIZE = WORD_SIZE_DEF,
  parameter int SEL_WIDTH = SEL_WIDTH_DEF
) (
  input  logic                 clk,
  input  logic                 clr,
  input  logic                 start,
  input  logic [WORD_SIZE-1:0] A,
  input  logic [WORD_SIZE-1:0] B,
  input  logic [SEL_WIDTH-1:0] ALU_Sel,
  output logic [WORD_SIZE-1:0] ALU_low,
  output logic [WORD_SIZE-1:0] ALU_high,
  output logic                 CarryOut,
  output logic                 DivZero,
  output logic                 busy,
  output logic                 done,
  output alu_state_e           state_dbg
);

  // Handshake: a request is taken on a rising edge with start=1 and busy=0; done is a
  // one-cycle pulse and the result outputs hold until the next accepted request's done.

  alu_state_e           state;
  alu_state_e           state_next;
  logic                 accept;
  logic                 sel_iter;
  logic                 iter_done;
  logic                 div_zero_q;
  logic [WORD_SIZE-1:0] iter_hi;
  logic [WORD_SIZE-1:0] iter_lo;
  logic [WORD_SIZE-1:0] b_mod;
  logic [WORD_SIZE-1:0] sc_low;
  logic                 sc_carry;
  logic [WORD_SIZE:0]   add_r;
  logic [WORD_SIZE:0]   sub_r;

  assign accept = start && (state == IDLE);

`ifdef ALU_SEQ_MULDIV_EN
  logic iter_start;

  assign sel_iter   = is_iter_op(int'(ALU_Sel));
  assign iter_start = accept && sel_iter;

  // The divide-by-zero flag depends on the operand sampled at acceptance, not the live B.
  always_ff @(posedge clk) begin
    if (clr) div_zero_q <= 1'b0;
    else if (iter_start) div_zero_q <= (int'(ALU_Sel) == OP_DIV) && (B == '0);
  end

  alu_muldiv_iter #(
    .WORD_SIZE(WORD_SIZE)
  ) u_iter (
    .clk  (clk),
    .clr  (clr),
    .start(iter_start),
    .op   (int'(ALU_Sel) == OP_DIV),
    .A    (A),
    .B    (B),
    .hi   (iter_hi),
    .lo   (iter_lo),
    .done (iter_done)
  );
`else
  assign sel_iter   = 1'b0;
  assign iter_done  = 1'b0;
  assign iter_hi    = '0;
  assign iter_lo    = '0;
  assign div_zero_q = 1'b0;
`endif

  // Shift/rotate counts wrap at the word size; a count of 0 leaves A unchanged.
  assign b_mod = B % WORD_SIZE'(WORD_SIZE);
  assign add_r = {1'b0, A} + {1'b0, B};
  assign sub_r = {1'b0, A} + {1'b0, ~B} + (WORD_SIZE + 1)'(1);

  always_comb begin
    sc_low   = '0;
    sc_carry = 1'b0;
    case (int'(ALU_Sel))
      OP_ADD: begin
        sc_low   = add_r[WORD_SIZE-1:0];
        sc_carry = add_r[WORD_SIZE];
      end
      OP_SUB: begin
        sc_low   = sub_r[WORD_SIZE-1:0];
        sc_carry = sub_r[WORD_SIZE];
      end
      OP_AND:  sc_low = A & B;
      OP_OR:   sc_low = A | B;
      OP_XOR:  sc_low = A ^ B;
      OP_SHR:  sc_low = A >> b_mod;
      OP_SHRA: sc_low = $signed(A) >>> b_mod;
      OP_SHL:  sc_low = A << b_mod;
      OP_ROR:  sc_low = (A >> b_mod) | (A << (WORD_SIZE'(WORD_SIZE) - b_mod));
      OP_ROL:  sc_low = (A << b_mod) | (A >> (WORD_SIZE'(WORD_SIZE) - b_mod));
      OP_NEG:  sc_low = '0 - A;
      OP_NOT:  sc_low = ~A;
      default: sc_low = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) state <= IDLE;
    else state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = sel_iter ? CALC : DONE;
      CALC:    if (iter_done) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      ALU_low  <= '0;
      ALU_high <= '0;
      CarryOut <= 1'b0;
      DivZero  <= 1'b0;
    end else if (accept && !sel_iter) begin
      ALU_low  <= sc_low;
      ALU_high <= '0;
      CarryOut <= sc_carry;
      DivZero  <= 1'b0;
    end else if ((state == CALC) && iter_done) begin
      ALU_low  <= iter_lo;
      ALU_high <= iter_hi;
      CarryOut <= 1'b0;
      DivZero  <= div_zero_q;
    end
  end

  assign busy      = (state != IDLE);
  assign done      = (state == DONE);
  assign state_dbg = state;

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: self-checking bench for alu_seq against an arithmetic reference model.
// Expectations follow ALU_SEQ_MULDIV_EN: defined -> real MUL/DIV, undefined -> codes 2/6 unused.
module tb_alu_seq;
  import alu_pkg::*;

  localparam int W      = 32;
  localparam int SW     = 6;
  localparam int RW     = 2 * W + 2;
  localparam int BUDGET = W + 8;

  logic            clk     = 1'b0;
  logic            clr     = 1'b1;
  logic            start   = 1'b0;
  logic [W-1:0]    A       = '0;
  logic [W-1:0]    B       = '0;
  logic [SW-1:0]   ALU_Sel = '0;
  logic [W-1:0]    ALU_low;
  logic [W-1:0]    ALU_high;
  logic            CarryOut;
  logic            DivZero;
  logic            busy;
  logic            done;
  alu_state_e      state_dbg;
  logic [RW-1:0]   res_obs;

  int n_tests = 0;
  int n_fail  = 0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  alu_seq #(
    .WORD_SIZE(W),
    .SEL_WIDTH(SW)
  ) dut (
    .clk      (clk),
    .clr      (clr),
    .start    (start),
    .A        (A),
    .B        (B),
    .ALU_Sel  (ALU_Sel),
    .ALU_low  (ALU_low),
    .ALU_high (ALU_high),
    .CarryOut (CarryOut),
    .DivZero  (DivZero),
    .busy     (busy),
    .done     (done),
    .state_dbg(state_dbg)
  );

  assign res_obs = {ALU_low, ALU_high, CarryOut, DivZero};

  // ---------------- reference model ----------------
  task automatic model(input int op, input logic [W-1:0] a, input logic [W-1:0] b,
                       output logic [RW-1:0] res);
    logic [W-1:0]   lo;
    logic [W-1:0]   hi;
    logic           c;
    logic           dz;
    logic [2*W-1:0] wide;
    int             sh;
    lo = '0; hi = '0; c = 1'b0; dz = 1'b0;
    sh = int'(b % W);
    case (op)
      0: begin wide = {32'b0, a} + {32'b0, b}; lo = wide[W-1:0]; c = wide[W]; end
      1: begin lo = a - b; c = (a >= b); end
`ifdef ALU_SEQ_MULDIV_EN
      2: begin
        if (b == 0) begin lo = '1; hi = a; dz = 1'b1; end
        else begin lo = a / b; hi = a % b; end
      end
      6: begin wide = {32'b0, a} * {32'b0, b}; hi = wide[2*W-1:W]; lo = wide[W-1:0]; end
`endif
      3: lo = a & b;
      4: lo = a | b;
      5: lo = a ^ b;
      7: lo = a >> sh;
      8: lo = $signed(a) >>> sh;
      9: lo = a << sh;
      10: begin lo = a; for (int i = 0; i < sh; i++) lo = {lo[0], lo[W-1:1]}; end
      11: begin lo = a; for (int i = 0; i < sh; i++) lo = {lo[W-2:0], lo[W-1]}; end
      12: lo = 32'd0 - a;
      13: lo = ~a;
      default: ;
    endcase
    res = {lo, hi, c, dz};
  endtask

  function automatic int exp_lat(input int op);
`ifdef ALU_SEQ_MULDIV_EN
    return ((op == 2) || (op == 6)) ? W + 1 : 1;
`else
    return 1;
`endif
  endfunction

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 5))
      0: return '0;
      1: return '1;
      2: return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  // ---------------- drivers ----------------
  // Returns at the falling edge just after the accepting rising edge (latency position 1).
  task automatic accept_op(input int op, input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    ALU_Sel = SW'(op);
    A       = a;
    B       = b;
    start   = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int pos, output int lat);
    lat = pos;
    while (done !== 1'b1 && lat < BUDGET) begin
      @(negedge clk);
      lat++;
    end
    if (done !== 1'b1) lat = -1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    clr = 1'b1; start = 1'b1; ALU_Sel = SW'(OP_ADD); A = '1; B = 32'd1;
    repeat (3) @(negedge clk);
    n_tests++;
    if ({res_obs, busy, done} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h, expected 0", {res_obs, busy, done});
    end
    n_tests++;
    if (state_dbg !== IDLE) begin
      n_fail++;
      $display("FAIL reset_state: got %0d, expected %0d", state_dbg, IDLE);
    end
    start = 1'b0;
    clr   = 1'b0;
  endtask

  task automatic test_directed();
    int           t_op [14] = '{0, 6, 2, 2, 8, 11, 1, 1, 10, 9, 12, 13, 14, 63};
    logic [W-1:0] t_a  [14] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd100, 32'd5, 32'h8000_0000,
                                32'h8000_0001, 32'd3, 32'd5, 32'h1234_5678, 32'h0000_000F,
                                32'd1, 32'h0F0F_0F0F, 32'hDEAD_BEEF, 32'hFFFF_FFFF};
    logic [W-1:0] t_b  [14] = '{32'd1, 32'hFFFF_FFFF, 32'd7, 32'd0, 32'd35, 32'd1, 32'd5,
                                32'd5, 32'd32, 32'd4, 32'd0, 32'd0, 32'h1234_5678, 32'd9};
    logic [RW-1:0] e;
    int lat;
    for (int i = 0; i < 14; i++) begin
      model(t_op[i], t_a[i], t_b[i], e);
      accept_op(t_op[i], t_a[i], t_b[i]);
      wait_done(1, lat);
      n_tests++;
      if (lat != exp_lat(t_op[i])) begin
        n_fail++;
        $display("FAIL directed_latency[%0d] op %0d: got %0d, expected %0d", i, t_op[i], lat, exp_lat(t_op[i]));
      end
      n_tests++;
      if (res_obs !== e) begin
        n_fail++;
        $display("FAIL directed_result[%0d] op %0d: got %h, expected %h", i, t_op[i], res_obs, e);
      end
    end
  endtask

  task automatic test_random();
    logic [RW-1:0] exp_q[$];
    logic [RW-1:0] e;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    int op;
    int lat;
    for (int i = 0; i < 30; i++) begin
      op = ($urandom_range(0, 7) == 0) ? int'($urandom_range(14, 63)) : int'($urandom_range(0, 13));
      a  = pick();
      b  = pick();
      model(op, a, b, e);
      exp_q.push_back(e);
      accept_op(op, a, b);
      wait_done(1, lat);
      e = exp_q.pop_front();
      n_tests++;
      if (lat != exp_lat(op)) begin
        n_fail++;
        $display("FAIL random_latency[%0d] op %0d: got %0d, expected %0d", i, op, lat, exp_lat(op));
      end
      n_tests++;
      if (res_obs !== e) begin
        n_fail++;
        $display("FAIL random_result[%0d] op %0d a %h b %h: got %h, expected %h", i, op, a, b, res_obs, e);
      end
    end
  endtask

  // Each request is issued in the idle cycle right after the previous done.
  task automatic test_back_to_back();
    logic [RW-1:0] e;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    int op;
    int lat;
    for (int i = 0; i < 8; i++) begin
      op = int'($urandom_range(0, 13));
      if (op == 2 || op == 6) op = 5;
      a = $urandom;
      b = $urandom;
      model(op, a, b, e);
      accept_op(op, a, b);
      wait_done(1, lat);
      n_tests++;
      if (lat != 1 || res_obs !== e) begin
        n_fail++;
        $display("FAIL back_to_back[%0d] op %0d: got lat %0d res %h, expected lat 1 res %h", i, op, lat, res_obs, e);
      end
    end
  endtask

  task automatic test_start_ignored();
    logic [RW-1:0] e_prev;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    int lat;
    a = $urandom;
    b = $urandom;
    model(OP_XOR, a, b, e_prev);
    accept_op(OP_XOR, a, b);
    wait_done(1, lat);
    n_tests++;
    if (lat != 1 || res_obs !== e_prev) begin
      n_fail++;
      $display("FAIL ignore_setup: got lat %0d res %h, expected lat 1 res %h", lat, res_obs, e_prev);
    end
    // start raised while done is showing lands on a busy edge and must be dropped
    ALU_Sel = SW'(OP_ADD); A = $urandom; B = $urandom; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n_tests++;
    if (done !== 1'b0 || busy !== 1'b0 || res_obs !== e_prev) begin
      n_fail++;
      $display("FAIL ignore_in_done: got done %b busy %b res %h, expected 0 0 %h", done, busy, res_obs, e_prev);
    end
    @(negedge clk);
    n_tests++;
    if (done !== 1'b0) begin
      n_fail++;
      $display("FAIL ignore_in_done_late: got done %b, expected 0", done);
    end
`ifdef ALU_SEQ_MULDIV_EN
    begin
      logic [RW-1:0] e_mul;
      logic [W-1:0]  ma;
      logic [W-1:0]  mb;
      int            pos;
      logic          saw;
      ma = $urandom;
      mb = $urandom;
      model(OP_MUL, ma, mb, e_mul);
      accept_op(OP_MUL, ma, mb);
      pos = 1;
      @(negedge clk);
      pos++;
      n_tests++;
      if (state_dbg !== CALC || busy !== 1'b1 || res_obs !== e_prev) begin
        n_fail++;
        $display("FAIL calc_hold: got state %0d busy %b res %h, expected %0d 1 %h", state_dbg, busy, res_obs, CALC, e_prev);
      end
      ALU_Sel = SW'(OP_DIV); A = $urandom; B = $urandom; start = 1'b1;
      @(negedge clk);
      pos++;
      start = 1'b0;
      for (int i = 0; i < 4; i++) begin
        A = $urandom; B = $urandom;
        @(negedge clk);
        pos++;
      end
      wait_done(pos, lat);
      n_tests++;
      if (lat != W + 1 || res_obs !== e_mul) begin
        n_fail++;
        $display("FAIL ignore_in_calc: got lat %0d res %h, expected lat %0d res %h", lat, res_obs, W + 1, e_mul);
      end
      saw = 1'b0;
      for (int i = 0; i < 4; i++) begin
        @(negedge clk);
        saw |= done;
      end
      n_tests++;
      if (saw !== 1'b0 || res_obs !== e_mul) begin
        n_fail++;
        $display("FAIL ignore_in_calc_after: got extra done %b res %h, expected 0 %h", saw, res_obs, e_mul);
      end
    end
`endif
  endtask

  task automatic test_clr_abort();
    logic [RW-1:0] e;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    int            op;
    int            hold;
    int            lat;
    logic          saw;
    model(OP_ADD, 32'd3, 32'd4, e);
    accept_op(OP_ADD, 32'd3, 32'd4);
    wait_done(1, lat);
    n_tests++;
    if (lat != 1 || res_obs !== e) begin
      n_fail++;
      $display("FAIL abort_setup: got lat %0d res %h, expected lat 1 res %h", lat, res_obs, e);
    end
`ifdef ALU_SEQ_MULDIV_EN
    op = OP_DIV; a = 32'd100; b = 32'd7; hold = 9;
`else
    op = OP_ADD; a = 32'h10; b = 32'h20; hold = 0;
`endif
    saw = 1'b0;
    accept_op(op, a, b);
    for (int i = 0; i < hold; i++) begin
      saw |= done;
      @(negedge clk);
    end
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    n_tests++;
    if ({res_obs, busy, done} !== '0) begin
      n_fail++;
      $display("FAIL abort_outputs: got %h, expected 0", {res_obs, busy, done});
    end
    for (int i = 0; i < W + 2; i++) begin
      @(negedge clk);
      saw |= done;
    end
    n_tests++;
    if (saw !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_no_done: got done seen %b, expected 0", saw);
    end
    model(OP_ADD, 32'hFFFF_FFFF, 32'd1, e);
    accept_op(OP_ADD, 32'hFFFF_FFFF, 32'd1);
    wait_done(1, lat);
    n_tests++;
    if (lat != 1 || res_obs !== e) begin
      n_fail++;
      $display("FAIL abort_next_add: got lat %0d res %h, expected lat 1 res %h", lat, res_obs, e);
    end
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_start_ignored();
    test_clr_abort();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
